// File: rtl/dca_matrix_row_lsu.sv
// dca_matrix_row_lsu
// Matrix row load/store unit between the memory fabric and the matrix MAC
// core's per-operand LSU ports. One instruction is handled at a time.
//
// A load issues strided memory reads. The returned rows are buffered in a
// small FIFO and streamed to the core, with wlast set on the final row.
// A store pulls rows from the core one at a time and writes each one to
// memory at a strided address. One row is one memory beat.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   sinst_*                   instruction in (valid/ready/data) and
//                             decode/execute pulses plus busy out
//   sload_tensor_row_*        load rows to the core (valid/last/data, ready in)
//   sstore_tensor_row_*       store rows from the core (valid/last out,
//                             ready/data in)
//   mem_req_*                 memory request (valid/ready/write/addr/wdata)
//   mem_rsp_*                 in-order read return, no backpressure
module dca_matrix_row_lsu #(
    parameter int BW_ADDR    = 32,
    parameter int BW_ROW     = 128,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sinst_wvalid,
    input  logic [63:0]       sinst_wdata,
    output logic              sinst_wready,
    output logic              sinst_decode_finish,
    output logic              sinst_execute_finish,
    output logic              sinst_busy,
    output logic              sload_tensor_row_wvalid,
    output logic              sload_tensor_row_wlast,
    output logic [BW_ROW-1:0] sload_tensor_row_wdata,
    input  logic              sload_tensor_row_wready,
    output logic              sstore_tensor_row_rvalid,
    output logic              sstore_tensor_row_rlast,
    input  logic              sstore_tensor_row_rready,
    input  logic [BW_ROW-1:0] sstore_tensor_row_rdata,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_write,
    output logic [BW_ADDR-1:0] mem_req_addr,
    output logic [BW_ROW-1:0] mem_req_wdata,
    input  logic              mem_rsp_valid,
    input  logic [BW_ROW-1:0] mem_rsp_rdata
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] DEPTH_LIM = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {IDLE, LOAD, ST_PULL, ST_WRITE, DONE} state_t;

    state_t              state;
    logic [7:0]          num_rows;
    logic [15:0]         stride;
    logic [BW_ADDR-1:0]  addr;
    logic [7:0]          row_idx;
    logic [7:0]          issued;
    logic [CW-1:0]       outstanding;
    logic [CW-1:0]       fifo_count;
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [BW_ROW-1:0]   fifo_mem [FIFO_DEPTH];
    logic [BW_ROW-1:0]   wr_row;
    logic                decode_q;

    logic                credit_ok;
    logic                load_req;
    logic                load_fire;
    logic                push;
    logic                load_valid;
    logic                pop;
    logic                last_row;
    logic [6:0]          unused_rsvd;

    assign unused_rsvd = sinst_wdata[7:1];

    // A read may only be issued while every in-flight read still has a
    // guaranteed FIFO slot, since responses cannot be backpressured.
    assign credit_ok  = ({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_LIM;
    assign load_req   = (state == LOAD) && (issued < num_rows) && credit_ok;
    assign load_fire  = load_req && mem_req_ready;
    assign push       = (state == LOAD) && mem_rsp_valid;
    assign load_valid = (state == LOAD) && (fifo_count != '0);
    assign pop        = load_valid && sload_tensor_row_wready;
    // row_idx counts popped rows on loads and written rows on stores.
    assign last_row   = (row_idx == num_rows - 8'd1);

    assign sinst_wready             = (state == IDLE);
    assign sinst_busy               = (state != IDLE);
    assign sinst_decode_finish      = decode_q;
    // An empty instruction enters DONE while the decode pulse is still high,
    // so it waits one extra cycle there before reporting completion.
    assign sinst_execute_finish     = (state == DONE) && !decode_q;
    assign sload_tensor_row_wvalid  = load_valid;
    assign sload_tensor_row_wlast   = load_valid && last_row;
    assign sload_tensor_row_wdata   = fifo_mem[rd_ptr];
    assign sstore_tensor_row_rvalid = (state == ST_PULL);
    assign sstore_tensor_row_rlast  = (state == ST_PULL) && last_row;
    assign mem_req_valid            = load_req || (state == ST_WRITE);
    assign mem_req_write            = (state == ST_WRITE);
    assign mem_req_addr             = addr;
    assign mem_req_wdata            = wr_row;

    // Main controller: instruction latch, address generation, read credit
    // tracking, load FIFO and the store pull/write handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            num_rows    <= '0;
            stride      <= '0;
            addr        <= '0;
            row_idx     <= '0;
            issued      <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            wr_row      <= '0;
            decode_q    <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
        end else begin
            decode_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (sinst_wvalid) begin
                        addr     <= BW_ADDR'(sinst_wdata[63:32]);
                        stride   <= sinst_wdata[31:16];
                        num_rows <= sinst_wdata[15:8];
                        row_idx  <= '0;
                        issued   <= '0;
                        decode_q <= 1'b1;
                        if (sinst_wdata[15:8] == 8'd0) begin
                            state <= DONE;
                        end else if (sinst_wdata[0]) begin
                            state <= ST_PULL;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (load_fire) begin
                        addr   <= addr + BW_ADDR'(stride);
                        issued <= issued + 8'd1;
                    end
                    if (load_fire && !push) begin
                        outstanding <= outstanding + CW'(1);
                    end else if (push && !load_fire) begin
                        outstanding <= outstanding - CW'(1);
                    end
                    if (push) begin
                        fifo_mem[wr_ptr] <= mem_rsp_rdata;
                        wr_ptr           <= wr_ptr + PW'(1);
                    end
                    if (push && !pop) begin
                        fifo_count <= fifo_count + CW'(1);
                    end else if (pop && !push) begin
                        fifo_count <= fifo_count - CW'(1);
                    end
                    if (pop) begin
                        rd_ptr  <= rd_ptr + PW'(1);
                        row_idx <= row_idx + 8'd1;
                        if (last_row) begin
                            state <= DONE;
                        end
                    end
                end
                ST_PULL: begin
                    if (sstore_tensor_row_rready) begin
                        wr_row <= sstore_tensor_row_rdata;
                        state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (mem_req_ready) begin
                        row_idx <= row_idx + 8'd1;
                        addr    <= addr + BW_ADDR'(stride);
                        state   <= last_row ? DONE : ST_PULL;
                    end
                end
                DONE: begin
                    if (!decode_q) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dca_matrix_row_lsu.sv
// tb_dca_matrix_row_lsu
// Testbench for dca_matrix_row_lsu. A behavioural memory with configurable
// read latency answers requests. Expected requests, load rows and store
// rlast flags are queued when an instruction is issued and are consumed by
// monitors as the DUT produces them.
module tb_dca_matrix_row_lsu;

    typedef struct {
        logic         wr;
        logic [31:0]  addr;
        logic [127:0] data;
    } req_t;

    typedef struct {
        logic [127:0] data;
        logic         last;
    } row_t;

    typedef struct {
        int           due;
        logic [127:0] data;
    } rsp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         sinst_wvalid = 1'b0;
    logic [63:0]  sinst_wdata = '0;
    logic         sinst_wready;
    logic         sinst_decode_finish;
    logic         sinst_execute_finish;
    logic         sinst_busy;
    logic         sload_tensor_row_wvalid;
    logic         sload_tensor_row_wlast;
    logic [127:0] sload_tensor_row_wdata;
    logic         load_ready = 1'b1;
    logic         sstore_tensor_row_rvalid;
    logic         sstore_tensor_row_rlast;
    logic         store_ready = 1'b1;
    logic [127:0] sstore_tensor_row_rdata;
    logic         mem_req_valid;
    logic         mem_ready = 1'b1;
    logic         mem_req_write;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_rsp_valid = 1'b0;
    logic [127:0] mem_rsp_rdata = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rsp_lat = 1;
    int rd_count = 0;
    int last_evt_cyc = 0;
    int st_ptr = 0;
    int st_base = 0;

    req_t         exp_req[$];
    row_t         exp_row[$];
    logic         exp_rlast[$];
    rsp_t         rsp_q[$];
    logic [127:0] st_src [0:7];

    dca_matrix_row_lsu #(
        .BW_ADDR(32),
        .BW_ROW(128),
        .FIFO_DEPTH(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sinst_wvalid(sinst_wvalid),
        .sinst_wdata(sinst_wdata),
        .sinst_wready(sinst_wready),
        .sinst_decode_finish(sinst_decode_finish),
        .sinst_execute_finish(sinst_execute_finish),
        .sinst_busy(sinst_busy),
        .sload_tensor_row_wvalid(sload_tensor_row_wvalid),
        .sload_tensor_row_wlast(sload_tensor_row_wlast),
        .sload_tensor_row_wdata(sload_tensor_row_wdata),
        .sload_tensor_row_wready(load_ready),
        .sstore_tensor_row_rvalid(sstore_tensor_row_rvalid),
        .sstore_tensor_row_rlast(sstore_tensor_row_rlast),
        .sstore_tensor_row_rready(store_ready),
        .sstore_tensor_row_rdata(sstore_tensor_row_rdata),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_ready),
        .mem_req_write(mem_req_write),
        .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rsp_rdata(mem_rsp_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign sstore_tensor_row_rdata = st_src[3'(st_ptr - st_base)];

    // The core's store source advances after the DUT has sampled the row.
    always @(posedge clk) begin
        if (!rst && sstore_tensor_row_rvalid && store_ready) begin
            st_ptr <= st_ptr + 1;
        end
    end

    function automatic logic [127:0] memData(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a, a + 32'h1111_1111, a[15:0], a[31:16]};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Memory side: check each accepted request, schedule read responses.
    always @(negedge clk) begin
        if (!rst && mem_req_valid && mem_ready) begin
            if (exp_req.size() == 0) begin
                checkOutput("req_expected", mem_req_valid, 1'b0);
            end else begin
                req_t r;
                r = exp_req.pop_front();
                checkOutput("req_write", mem_req_write, r.wr);
                checkOutput("req_addr", mem_req_addr, r.addr);
                if (r.wr) begin
                    checkOutput("req_wdata", mem_req_wdata, r.data);
                end
            end
            if (mem_req_write) begin
                last_evt_cyc = cyc + 1;
            end else begin
                rd_count++;
                rsp_q.push_back('{due: cyc + rsp_lat, data: memData(mem_req_addr)});
            end
        end
    end

    always @(posedge clk) begin
        #1;
        mem_rsp_valid = 1'b0;
        if (rsp_q.size() != 0 && rsp_q[0].due <= cyc) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = rsp_q[0].data;
            void'(rsp_q.pop_front());
        end
    end

    // Core side: check every load row popped and every store row pulled.
    always @(negedge clk) begin
        if (!rst && sload_tensor_row_wvalid && load_ready) begin
            if (exp_row.size() == 0) begin
                checkOutput("load_row_expected", sload_tensor_row_wvalid, 1'b0);
            end else begin
                row_t w;
                w = exp_row.pop_front();
                checkOutput("load_row_data", sload_tensor_row_wdata, w.data);
                checkOutput("load_row_last", sload_tensor_row_wlast, w.last);
                if (w.last) begin
                    last_evt_cyc = cyc + 1;
                end
            end
        end
        if (!rst && sstore_tensor_row_rvalid && store_ready) begin
            if (exp_rlast.size() == 0) begin
                checkOutput("store_row_expected", sstore_tensor_row_rvalid, 1'b0);
            end else begin
                checkOutput("store_rlast", sstore_tensor_row_rlast, exp_rlast.pop_front());
            end
        end
    end

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_wready"}, sinst_wready, 1'b1);
        checkOutput({tag, "_busy"}, sinst_busy, 1'b0);
        checkOutput({tag, "_decode"}, sinst_decode_finish, 1'b0);
        checkOutput({tag, "_execute"}, sinst_execute_finish, 1'b0);
        checkOutput({tag, "_req_valid"}, mem_req_valid, 1'b0);
        checkOutput({tag, "_req_write"}, mem_req_write, 1'b0);
        checkOutput({tag, "_req_addr"}, mem_req_addr, 32'h0);
        checkOutput({tag, "_row_valid"}, sload_tensor_row_wvalid, 1'b0);
        checkOutput({tag, "_row_last"}, sload_tensor_row_wlast, 1'b0);
        checkOutput({tag, "_row_data"}, sload_tensor_row_wdata, 128'h0);
        checkOutput({tag, "_rvalid"}, sstore_tensor_row_rvalid, 1'b0);
    endtask

    // Queue expectations, hand the instruction over, check the decode pulse.
    task automatic applyStimulus(input logic op, input logic [31:0] base,
                                 input logic [15:0] stride, input logic [7:0] n);
        logic [31:0] a;
        int          acc;
        a = base;
        st_base = st_ptr;
        for (int i = 0; i < int'(n); i++) begin
            if (!op) begin
                exp_req.push_back('{wr: 1'b0, addr: a, data: 128'h0});
                exp_row.push_back('{data: memData(a), last: (i == int'(n) - 1)});
            end else begin
                exp_req.push_back('{wr: 1'b1, addr: a, data: st_src[i]});
                exp_rlast.push_back(i == int'(n) - 1);
            end
            a = a + {16'h0, stride};
        end
        @(posedge clk); #1;
        sinst_wvalid = 1'b1;
        sinst_wdata  = {base, stride, n, 7'h0, op};
        @(negedge clk);
        checkOutput("inst_wready", sinst_wready, 1'b1);
        @(posedge clk); #1;
        acc = cyc;
        sinst_wvalid = 1'b0;
        if (n == 8'd0) begin
            last_evt_cyc = acc + 1;
        end
        @(negedge clk);
        checkOutput("decode_pulse", sinst_decode_finish, 1'b1);
        checkOutput("decode_busy", sinst_busy, 1'b1);
        checkOutput("decode_wready", sinst_wready, 1'b0);
    endtask

    task automatic waitExecute(input string tag);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 200 && !seen; k++) begin
            @(negedge clk);
            if (sinst_execute_finish) begin
                seen = 1'b1;
                checkOutput({tag, "_exec_cycle"}, cyc, last_evt_cyc);
                checkOutput({tag, "_exec_busy"}, sinst_busy, 1'b1);
            end
        end
        if (!seen) begin
            checkOutput({tag, "_exec_timeout"}, sinst_execute_finish, 1'b1);
        end
        @(negedge clk);
        checkOutput({tag, "_exec_one_cycle"}, sinst_execute_finish, 1'b0);
        checkOutput({tag, "_idle_busy"}, sinst_busy, 1'b0);
        checkOutput({tag, "_idle_wready"}, sinst_wready, 1'b1);
        checkOutput({tag, "_left_req"}, exp_req.size(), 0);
        checkOutput({tag, "_left_rows"}, exp_row.size(), 0);
        checkOutput({tag, "_left_rlast"}, exp_rlast.size(), 0);
    endtask

    initial begin
        int rd_base;
        for (int i = 0; i < 8; i++) st_src[i] = '0;

        repeat (2) @(negedge clk);
        checkResetOutputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        $display("[TB] load 3 rows from 0x1000 stride 0x10");
        applyStimulus(1'b0, 32'h0000_1000, 16'h0010, 8'd3);
        waitExecute("load3");

        $display("[TB] load 8 rows with core backpressure");
        load_ready = 1'b0;
        rd_base = rd_count;
        applyStimulus(1'b0, 32'h0000_5000, 16'h0080, 8'd8);
        repeat (10) @(negedge clk);
        checkOutput("stall_issued", rd_count - rd_base, 4);
        checkOutput("stall_req_valid", mem_req_valid, 1'b0);
        checkOutput("stall_row_valid", sload_tensor_row_wvalid, 1'b1);
        @(posedge clk); #1;
        load_ready = 1'b1;
        waitExecute("load8");

        $display("[TB] store 2 rows to 0x2000 stride 0x40 with memory stall");
        st_src[0] = {16{8'hAA}};
        st_src[1] = {16{8'hBB}};
        mem_ready = 1'b0;
        applyStimulus(1'b1, 32'h0000_2000, 16'h0040, 8'd2);
        for (int k = 0; k < 20 && !mem_req_valid; k++) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            checkOutput("hold_valid", mem_req_valid, 1'b1);
            checkOutput("hold_write", mem_req_write, 1'b1);
            checkOutput("hold_addr", mem_req_addr, 32'h0000_2000);
            checkOutput("hold_wdata", mem_req_wdata, {16{8'hAA}});
            if (k < 2) @(negedge clk);
        end
        @(posedge clk); #1;
        mem_ready = 1'b1;
        waitExecute("store2");

        $display("[TB] zero-row load and store");
        applyStimulus(1'b0, 32'h0000_6000, 16'h0010, 8'd0);
        waitExecute("zero_load");
        applyStimulus(1'b1, 32'h0000_7000, 16'h0010, 8'd0);
        waitExecute("zero_store");

        $display("[TB] load with address wrap");
        applyStimulus(1'b0, 32'hFFFF_FFF0, 16'h0020, 8'd2);
        waitExecute("wrap");

        $display("[TB] reset during a load with reads in flight");
        rsp_lat = 4;
        rd_base = rd_count;
        applyStimulus(1'b0, 32'h0000_3000, 16'h0004, 8'd4);
        for (int k = 0; k < 20 && (rd_count - rd_base) < 2; k++) @(negedge clk);
        checkOutput("abort_issued", rd_count - rd_base, 2);
        @(posedge clk); #1;
        rst = 1'b1;
        exp_req.delete();
        exp_row.delete();
        #1;
        checkResetOutputs("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 20 && rsp_q.size() != 0; k++) @(negedge clk);
        repeat (3) @(negedge clk);
        checkOutput("late_rsp_dropped", rsp_q.size(), 0);
        checkOutput("late_row_valid", sload_tensor_row_wvalid, 1'b0);
        checkOutput("late_busy", sinst_busy, 1'b0);
        rsp_lat = 1;
        applyStimulus(1'b0, 32'h0000_4000, 16'h0010, 8'd1);
        waitExecute("after_abort");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/dca_matrix_row_lsu.md
Name: dca_matrix_row_lsu

Overview:
- Matrix load/store unit that sits between the memory fabric and the matrix MAC core's per-operand LSU ports (inst, load-row, store-row).
- Accepts one LSU instruction at a time.
- Load: issues strided memory reads and streams the returned rows to the core with a last flag.
- Store: pulls rows from the core and issues strided memory writes.
- One row equals one memory beat.

Parameters:
- BW_ADDR, 32, memory address width; address arithmetic wraps modulo 2^BW_ADDR.
- BW_ROW, 128, row width in bits (MATRIX_NUM_COL × BW_TENSOR_SCALAR for the 8×16b configuration).
- FIFO_DEPTH, 4, load-row buffer depth; power of two, minimum 2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- sinst_wvalid  in  1  instruction valid
- sinst_wdata  in  64  instruction: [63:32] base_addr, [31:16] stride in bytes (unsigned), [15:8] num_rows, [7:1] reserved, [0] op (0 = load, 1 = store)
- sinst_wready  out  1  instruction accept
- sinst_decode_finish  out  1  one-cycle pulse, instruction decoded
- sinst_execute_finish  out  1  one-cycle pulse, instruction complete
- sinst_busy  out  1  instruction in progress
- sload_tensor_row_wvalid  out  1  load row valid
- sload_tensor_row_wlast  out  1  final row of the instruction
- sload_tensor_row_wdata  out  BW_ROW  load row data
- sload_tensor_row_wready  in  1  core accepts the row
- sstore_tensor_row_rvalid  out  1  LSU requests a store row
- sstore_tensor_row_rlast  out  1  final store row
- sstore_tensor_row_rready  in  1  core supplies the row
- sstore_tensor_row_rdata  in  BW_ROW  store row data
- mem_req_valid  out  1  memory request
- mem_req_ready  in  1  memory accepts the request
- mem_req_write  out  1  1 = write, 0 = read
- mem_req_addr  out  BW_ADDR  byte address
- mem_req_wdata  out  BW_ROW  write data
- mem_rsp_valid  in  1  read data return; in order, no backpressure
- mem_rsp_rdata  in  BW_ROW  read data

Behaviour:
- Reset (asynchronous, rst=1):
  - State = IDLE; all counters and the FIFO cleared.
  - All outputs 0 except sinst_wready = 1.
  - Reset mid-operation abandons the instruction. Responses arriving after reset are dropped.
- States: IDLE, LOAD, ST_PULL, ST_WRITE, DONE.
- IDLE:
  - sinst_wready = 1.
  - On wvalid&wready, latch the fields; row_idx = 0, addr = base_addr.
  - Next cycle: decode_finish = 1 for one cycle, busy = 1 from this cycle.
  - Next state: num_rows = 0 → DONE (no memory traffic); op = 0 → LOAD; op = 1 → ST_PULL.
- sinst_wready = 0 in every state other than IDLE.
- sinst_busy = 1 whenever state ≠ IDLE.
- LOAD:
  - mem_req_valid = 1 with write = 0 while issued < num_rows and (outstanding + fifo_count) < FIFO_DEPTH. This credit rule guarantees no response is ever lost.
  - On req handshake: addr += stride, issued += 1, outstanding += 1.
  - On mem_rsp_valid: push into the FIFO, outstanding −= 1.
  - A simultaneous issue and response in the same cycle leaves outstanding unchanged.
  - FIFO head drives wdata and wvalid = (fifo_count ≠ 0).
  - wlast = 1 when the head row is row num_rows−1.
  - Pop on wvalid&wready. Same-cycle push and pop on a full FIFO is legal and keeps the count.
  - Popping the last row → DONE.
  - Row data is not modified.
- ST_PULL:
  - rvalid = 1; rlast = (row_idx == num_rows−1).
  - On rvalid&rready: latch rdata into the write register → ST_WRITE.
- ST_WRITE:
  - mem_req_valid = 1, write = 1, addr, wdata = latched row. Hold stable until ready.
  - On handshake: row_idx += 1, addr += stride.
  - If that was the last row → DONE, else → ST_PULL.
  - Throughput is one row per 2 cycles minimum.
- DONE:
  - execute_finish = 1 for exactly one cycle → IDLE.
  - busy drops with the IDLE transition, so busy is still 1 during the execute_finish cycle.
- Latency:
  - Instruction accept → decode_finish: 1 cycle.
  - Final load-row pop or final store-write accept → execute_finish: 1 cycle.
- Stride 0 is legal: every access goes to the same address.
- Address overflow wraps silently.

Test Plan:
- Load, base 0x1000, stride 0x10, num_rows 3, memory always ready with 1-cycle response: reads issued to 0x1000/0x1010/0x1020 → three rows out in order, wlast only on the third, decode_finish at T+1, execute_finish one cycle after the third pop.
- Load, num_rows 8, FIFO_DEPTH 4, wready held 0: issue stalls at 4 credits (outstanding + fifo_count = 4), no response is lost → releasing wready drains all 8 rows with correct data.
- Store, base 0x2000, stride 0x40, num_rows 2, core supplies 0xAA… then 0xBB…: writes 0xAA… @0x2000 and 0xBB… @0x2040; rlast only on row 1; mem_req held stable across 3 cycles of mem_req_ready=0.
- num_rows 0 (either op): decode_finish, then execute_finish next cycle; mem_req_valid and the row valids never asserted.
- Base 0xFFFFFFF0, stride 0x20, load, 2 rows → addresses 0xFFFFFFF0 then 0x00000010.
- rst asserted mid-load with 2 outstanding reads → outputs return to reset values immediately and late responses are ignored; a following 1-row load completes correctly.
